// File: rtl/pipe_control.sv
// Pipelined main control: ID decode, ID->EX->MEM flag pipeline, load-use/flush/freeze handling.
// Optional memory-timeout logic is built when PIPE_CTRL_TIMEOUT_EN is defined.
module pipe_control #(
  parameter int REGW     = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  logic            id_vld,
  input  logic [1:0]      opcode,
  input  logic [2:0]      funct,
  input  logic [REGW-1:0] rs_addr,
  input  logic [REGW-1:0] rt_addr,
  input  logic [REGW-1:0] rd_addr,
  input  logic            brnch_taken,
  input  logic            mem_ready,
  output logic            stall_flg,
  output logic            flush_flg,
  output logic            nop_flg,
  output logic            ex_jmp_flg,
  output logic            ex_brnch_flg,
  output logic            mem_rd_flg,
  output logic            mem_wrt_flg,
  output logic            mem_err
);

  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_J = 2'b10;
  localparam logic [1:0] OP_B = 2'b11;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  if (WAIT_MAX < 1) begin : g_bad_wait_max
    $error("pipe_control: WAIT_MAX must be at least 1");
  end

  state_t          state;
  logic            ex_rd_flg;
  logic            ex_wrt_flg;
  logic [REGW-1:0] ex_dst;

  logic dec_jmp, dec_brnch, dec_rd, dec_wrt;
  logic freeze, flush, hazard, timeout;

  always_comb begin
    dec_jmp   = 1'b0;
    dec_brnch = 1'b0;
    dec_rd    = 1'b0;
    dec_wrt   = 1'b0;
    if (id_vld) begin
      case (opcode)
        OP_J: dec_jmp   = 1'b1;
        OP_B: dec_brnch = 1'b1;
        OP_I: begin
          dec_rd  = (funct == 3'b100);
          dec_wrt = (funct == 3'b010) || (funct == 3'b011) || (funct == 3'b101);
        end
        default: ;
      endcase
    end
  end

  // Priority chain: freeze masks everything, flush masks load-use and stall_in.
  assign freeze = (mem_rd_flg | mem_wrt_flg) & ~mem_ready;
  assign flush  = ~freeze & (ex_jmp_flg | (ex_brnch_flg & brnch_taken));
  assign hazard = ~freeze & ~flush &
                  (stall_in | (id_vld & ex_rd_flg & ((ex_dst == rs_addr) | (ex_dst == rt_addr))));

  assign stall_flg = freeze | hazard;
  assign flush_flg = flush;

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam int CNTW = $clog2(WAIT_MAX + 1);
  logic [CNTW-1:0] wait_cnt;
  assign timeout = (state == MEM_WAIT) & ~mem_ready & (wait_cnt == CNTW'(WAIT_MAX));
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
`ifdef PIPE_CTRL_TIMEOUT_EN
      wait_cnt <= '0;
      mem_err  <= 1'b0;
`endif
    end else begin
`ifdef PIPE_CTRL_TIMEOUT_EN
      mem_err <= timeout;
`endif
      case (state)
        RUN: begin
          if (freeze) begin
            state <= MEM_WAIT;
`ifdef PIPE_CTRL_TIMEOUT_EN
            wait_cnt <= CNTW'(1);
`endif
          end
        end
        MEM_WAIT: begin
          if (mem_ready || timeout) begin
            state <= RUN;
`ifdef PIPE_CTRL_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
`ifdef PIPE_CTRL_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + CNTW'(1);
          end
`endif
        end
        default: state <= RUN;
      endcase
    end
  end

  // A timeout drops the stuck access; the rest of the pipe stays frozen for that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nop_flg      <= 1'b0;
      ex_jmp_flg   <= 1'b0;
      ex_brnch_flg <= 1'b0;
      ex_rd_flg    <= 1'b0;
      ex_wrt_flg   <= 1'b0;
      ex_dst       <= '0;
      mem_rd_flg   <= 1'b0;
      mem_wrt_flg  <= 1'b0;
    end else if (timeout) begin
      mem_rd_flg  <= 1'b0;
      mem_wrt_flg <= 1'b0;
    end else if (!freeze) begin
      mem_rd_flg  <= ex_rd_flg;
      mem_wrt_flg <= ex_wrt_flg;
      if (flush || hazard) begin
        nop_flg      <= 1'b1;
        ex_jmp_flg   <= 1'b0;
        ex_brnch_flg <= 1'b0;
        ex_rd_flg    <= 1'b0;
        ex_wrt_flg   <= 1'b0;
        ex_dst       <= '0;
      end else begin
        nop_flg      <= ~id_vld;
        ex_jmp_flg   <= dec_jmp;
        ex_brnch_flg <= dec_brnch;
        ex_rd_flg    <= dec_rd;
        ex_wrt_flg   <= dec_wrt;
        ex_dst       <= rd_addr;
      end
    end
  end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined successor to the NanoQuarter main control. It decodes the 2-bit opcode and 3-bit funct of the instruction in ID, and carries the control flags through registered EX and MEM stages. It detects load-use hazards and inserts bubbles. It flushes the younger instruction on a jump or a taken branch, and freezes the pipe while data memory withholds `mem_ready`. It sits between fetch/decode and the EX/MEM datapath.

## Interface
- `REGW`, 3: register address width.
- `WAIT_MAX`, 15: maximum freeze cycles before a memory timeout (timeout build only); must be ≥1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  external stall; forces a bubble into EX.
- `id_vld`  in  1  ID instruction valid.
- `opcode`  in  2  ID opcode: 00 R, 01 I, 10 J, 11 B.
- `funct`  in  3  ID funct.
- `rs_addr`, `rt_addr`, `rd_addr`  in  REGW  ID source and destination fields.
- `brnch_taken`  in  1  EX branch resolution; meaningful only when `ex_brnch_flg`=1.
- `mem_ready`  in  1  data memory completes the current MEM access.
- `stall_flg`  out  1  combinational; hold PC and the ID register.
- `flush_flg`  out  1  combinational; discard the fetched instruction.
- `nop_flg`  out  1  registered; the EX slot is a bubble.
- `ex_jmp_flg`, `ex_brnch_flg`  out  1  registered EX-stage flags.
- `mem_rd_flg`, `mem_wrt_flg`  out  1  registered MEM-stage flags.
- `mem_err`  out  1  registered one-cycle timeout pulse.

## Operation
- **Decode (ID, combinational).** Decode applies only when `id_vld`=1; otherwise the instruction is a bubble.
  - J sets jmp; B sets brnch.
  - I-type: lw (100) sets rd; sui (010), sbi (011) and sw (101) set wrt.
  - lui (000), lbi (001), other I-type funct values and all R-type instructions set no flags.
- **Stage registers.** ID→EX holds jmp, brnch, rd, wrt, nop and `ex_dst`=`rd_addr`. EX→MEM holds rd and wrt.
- **freeze** = (`mem_rd_flg`|`mem_wrt_flg`) & ~`mem_ready`. While frozen, all stage registers hold and `stall_flg`=1.
- **flush** = ~freeze & (`ex_jmp_flg` | (`ex_brnch_flg` & `brnch_taken`)).
  - Drives `flush_flg`=1.
  - The ID instruction enters EX as a bubble (`nop_flg`=1 and all flags 0).
- **Load-use** = ~freeze & ~flush & `id_vld` & EX rd & (`ex_dst`==`rs_addr` | `ex_dst`==`rt_addr`).
  - Drives `stall_flg`=1.
  - A bubble enters EX and the ID instruction is held for one cycle.
- **stall_in**, when not frozen, behaves like load-use.
- **Priority:** freeze > flush > load-use/`stall_in`. A flush takes precedence over a pending load-use on the same cycle.
- **FSM:** RUN and MEM_WAIT.
  - RUN→MEM_WAIT when freeze is true.
  - MEM_WAIT→RUN when `mem_ready`=1, or on timeout.
  - Freeze and `stall_flg` apply in RUN too, on the first freeze cycle.
- **Wait counter** (timeout build only; see Configuration). It counts freeze cycles and clears on leaving MEM_WAIT.

## Timing
- **Reset:** every output 0, all stage registers cleared to bubble, state RUN, counter 0. Reset mid-wait abandons the access.
- **Latency:** ID decode appears on `ex_*` one edge later, and on `mem_*` two edges later.
- `stall_flg` and `flush_flg` are valid in the same cycle as their cause.
- **Memory handshake:** the access completes on the edge where `mem_ready`=1, and the pipe advances on that same edge. `mem_ready` is ignored when the MEM stage holds no access.
- A zero-wait memory (`mem_ready` tied 1) never freezes.
- A back-to-back load-use after a freeze resolves normally once the pipe is unfrozen.
- `brnch_taken` sampled while frozen has no effect; the flush occurs on the first unfrozen cycle.

## Configuration
- **`PIPE_CTRL_TIMEOUT_EN` defined:** when the counter reaches `WAIT_MAX` with `mem_ready` still 0:
  - on the next edge, `mem_err` pulses for 1 cycle;
  - the MEM stage is cleared to a bubble;
  - the FSM returns to RUN.
- **`PIPE_CTRL_TIMEOUT_EN` undefined:** the FSM waits indefinitely, the counter is not instantiated and `mem_err` is tied 0.

## Test plan
- **Decode:** sequence lw, sw, sui, lui, J, B with `mem_ready`=1.
  - 2 edges after lw: `mem_rd_flg`=1.
  - 2 edges after sw and sui: `mem_wrt_flg`=1.
  - lui: no flags.
  - J: `ex_jmp_flg`=1 after 1 edge; B: `ex_brnch_flg`=1 after 1 edge.
- **Load-use:** lw with `rd_addr`=3, then an R-type with `rs_addr`=3.
  - `stall_flg`=1 for exactly 1 cycle, then `nop_flg`=1 in EX.
  - With `rs_addr`=4 instead: no stall.
- **Branch:** B in EX with `brnch_taken`=1 → `flush_flg`=1 for 1 cycle, and the next EX slot has `nop_flg`=1. With `brnch_taken`=0 → no flush.
- **Memory wait:** lw in MEM with `mem_ready`=0 for 3 cycles.
  - `stall_flg`=1 and all stage registers frozen for 3 cycles.
  - Advance on the edge where `mem_ready` rises.
- **Priority:** load-use and a J in EX in the same cycle → flush wins, no extra stall cycle.
- **Timeout** (macro on, `WAIT_MAX`=4): `mem_ready` held 0 → `mem_err` pulses once, MEM stage cleared, FSM back in RUN. Asserting `rst_n`=0 mid-wait clears all outputs at once.
